// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp -- multi-port register file with scoreboard
//
// Purpose:
//   2^AW x DW register file with two prioritised write ports and NR
//   combinational read ports. Every read port sees same-cycle write data
//   through a bypass. A busy bit per register is set by a reservation at
//   issue and cleared by writeback. The pipeline uses this bit for hazard
//   detection. Register 0 is hard-wired to zero and is never busy.
//
// Parameters:
//   DW  data width in bits
//   AW  address width (depth = 2^AW)
//   NR  number of read ports (1..4)
//
// Ports:
//   clk    rising-edge clock
//   rstd   asynchronous active-high reset
//   ra     NR packed read addresses, port k at [k*AW +: AW]
//   rr     NR packed read data,      port k at [k*DW +: DW]
//   rbusy  busy view of the register on each read port (post-bypass)
//   we0/wa0/wd0  write port 0 (lower priority)
//   we1/wa1/wd1  write port 1 (wins on an address clash)
//   rsv/rsv_a    reserve request: mark register rsv_a busy
//   wcol   registered pulse: both ports wrote the same nonzero address
//   nbusy  registered count of busy registers
// ---------------------------------------------------------------------------
module reg_file_mp #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2
) (
  input  logic             clk,
  input  logic             rstd,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*DW-1:0] rr,
  output logic [NR-1:0]    rbusy,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic [DW-1:0]    wd0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [DW-1:0]    wd1,
  input  logic             rsv,
  input  logic [AW-1:0]    rsv_a,
  output logic             wcol,
  output logic [AW:0]      nbusy
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] ZERO_A = {AW{1'b0}};

  // Population count of the busy vector; bit 0 is always clear so the
  // result never exceeds DEPTH-1.
  function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] c;
    c = {(AW+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Storage and scoreboard state
  logic [DW-1:0]    mem_r [DEPTH];
  logic [DEPTH-1:0] busy_r;
  logic [AW:0]      nbusy_r;
  logic             wcol_r;

  // Qualified requests: anything aimed at register 0 is dropped here, so
  // nothing downstream has to special-case it again.
  logic             wr0_s;
  logic             wr1_s;
  logic             rsv_s;
  logic [DEPTH-1:0] busy_nxt_s;
  logic             wcol_nxt_s;

  assign wr0_s = we0 & (wa0 != ZERO_A);
  assign wr1_s = we1 & (wa1 != ZERO_A);
  assign rsv_s = rsv & (rsv_a != ZERO_A);

  // Next busy vector: a reservation beats a writeback on the same register
  // because the new producer supersedes the one that is retiring.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int a = 1; a < DEPTH; a++) begin
      if (rsv_s && (rsv_a == AW'(a))) begin
        busy_nxt_s[a] = 1'b1;
      end else if ((wr0_s && (wa0 == AW'(a))) || (wr1_s && (wa1 == AW'(a)))) begin
        busy_nxt_s[a] = 1'b0;
      end else begin
        busy_nxt_s[a] = busy_r[a];
      end
    end
    busy_nxt_s[0] = 1'b0;
  end

  // A collision is only meaningful for a real register; writes to r0 are
  // discarded and must not raise the flag.
  always_comb begin
    wcol_nxt_s = we0 & we1 & (wa0 == wa1) & (wa0 != ZERO_A);
  end

  // Scoreboard, busy count and collision flag registers
  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      busy_r  <= {DEPTH{1'b0}};
      nbusy_r <= {(AW+1){1'b0}};
      wcol_r  <= 1'b0;
    end else begin
      busy_r  <= busy_nxt_s;
      nbusy_r <= popcount(busy_nxt_s);
      wcol_r  <= wcol_nxt_s;
    end
  end

  // Register storage; port 1 is tested first so it wins an address clash
  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_r[a] <= {DW{1'b0}};
      end
    end else begin
      for (int a = 1; a < DEPTH; a++) begin
        if (wr1_s && (wa1 == AW'(a))) begin
          mem_r[a] <= wd1;
        end else if (wr0_s && (wa0 == AW'(a))) begin
          mem_r[a] <= wd0;
        end else begin
          mem_r[a] <= mem_r[a];
        end
      end
    end
  end

  assign wcol  = wcol_r;
  assign nbusy = nbusy_r;

  // Read ports: one bypass mux and busy view per port
  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [AW-1:0] addr_s;
    logic          hit0_s;
    logic          hit1_s;
    logic          rsv_hit_s;
    logic [DW-1:0] data_s;
    logic          busy_s;

    assign addr_s    = ra[k*AW +: AW];
    assign hit0_s    = wr0_s & (wa0 == addr_s);
    assign hit1_s    = wr1_s & (wa1 == addr_s);
    assign rsv_hit_s = rsv_s & (rsv_a == addr_s);

    // Read data: the bypass is suppressed while reset is held so that
    // reads in reset are zero regardless of the write ports.
    always_comb begin
      data_s = {DW{1'b0}};
      if (rstd) begin
        data_s = {DW{1'b0}};
      end else if (addr_s == ZERO_A) begin
        data_s = {DW{1'b0}};
      end else if (hit1_s) begin
        data_s = wd1;
      end else if (hit0_s) begin
        data_s = wd0;
      end else begin
        data_s = mem_r[addr_s];
      end
    end

    // Busy view: a writeback this cycle retires the hazard early unless a
    // reservation for the same register is arriving at the same time.
    // A fresh reservation on an idle register shows up next cycle.
    always_comb begin
      busy_s = 1'b0;
      if (rstd) begin
        busy_s = 1'b0;
      end else if (addr_s == ZERO_A) begin
        busy_s = 1'b0;
      end else if ((hit0_s || hit1_s) && !rsv_hit_s) begin
        busy_s = 1'b0;
      end else begin
        busy_s = busy_r[addr_s];
      end
    end

    assign rr[k*DW +: DW] = data_s;
    assign rbusy[k]       = busy_s;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp -- self-checking bench for reg_file_mp
//
// Drives a default instance (DW=32, AW=5, NR=2) through directed scenarios
// and a randomized run checked against an array-based reference model, and
// a second instance (AW=3, NR=4) through a port-slicing scenario.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rstd;
  logic [9:0]  ra;
  logic [63:0] rr;
  logic [1:0]  rbusy;
  logic        we0, we1, rsv;
  logic [4:0]  wa0, wa1, rsv_a;
  logic [31:0] wd0, wd1;
  logic        wcol;
  logic [5:0]  nbusy;

  logic [11:0]  ra4;
  logic [127:0] rr4;
  logic [3:0]   rbusy4;
  logic         we0_4, we1_4, rsv4;
  logic [2:0]   wa0_4, wa1_4, rsv_a4;
  logic [31:0]  wd0_4, wd1_4;
  logic         wcol4;
  logic [3:0]   nbusy4;

  int tests = 0;
  int fails = 0;

  // reference model of the default instance
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  int          m_nbusy;
  bit          m_wcol;

  reg_file_mp #(.DW(32), .AW(5), .NR(2)) dut (
    .clk(clk), .rstd(rstd), .ra(ra), .rr(rr), .rbusy(rbusy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .rsv(rsv), .rsv_a(rsv_a), .wcol(wcol), .nbusy(nbusy)
  );

  reg_file_mp #(.DW(32), .AW(3), .NR(4)) dut4 (
    .clk(clk), .rstd(rstd), .ra(ra4), .rr(rr4), .rbusy(rbusy4),
    .we0(we0_4), .wa0(wa0_4), .wd0(wd0_4), .we1(we1_4), .wa1(wa1_4), .wd1(wd1_4),
    .rsv(rsv4), .rsv_a(rsv_a4), .wcol(wcol4), .nbusy(nbusy4)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
    m_nbusy = 0;
    m_wcol  = 1'b0;
  endtask

  // Apply one clock edge to the model: writes in port order (port 1 last so
  // it wins), writebacks free registers, then reservations claim them.
  task automatic model_edge();
    if (rstd) begin
      model_clear();
    end else begin
      m_wcol = we0 && we1 && (wa0 == wa1) && (wa0 != 5'd0);
      if (we0 && wa0 != 5'd0) begin m_mem[wa0] = wd0; m_busy[wa0] = 1'b0; end
      if (we1 && wa1 != 5'd0) begin m_mem[wa1] = wd1; m_busy[wa1] = 1'b0; end
      if (rsv && rsv_a != 5'd0) m_busy[rsv_a] = 1'b1;
      m_nbusy = 0;
      for (int i = 1; i < 32; i++) m_nbusy += int'(m_busy[i]);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    bit written;
    if (a == 5'd0) return 1'b0;
    written = (we0 && wa0 == a) || (we1 && wa1 == a);
    if (written && !(rsv && rsv_a == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [4:0] pick_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; wa0 = 5'd0; wd0 = 32'h0;
    we1 = 1'b0; wa1 = 5'd0; wd1 = 32'h0;
    rsv = 1'b0; rsv_a = 5'd0;
    we0_4 = 1'b0; wa0_4 = 3'd0; wd0_4 = 32'h0;
    we1_4 = 1'b0; wa1_4 = 3'd0; wd1_4 = 32'h0;
    rsv4 = 1'b0; rsv_a4 = 3'd0;
  endtask

  task automatic test_reset();
    rstd = 1'b1; idle(); ra = {5'd0, 5'd3}; ra4 = 12'h0;
    #12;
    tests++; if (rr !== 64'h0) begin fails++; $display("FAIL reset_rr: got %h expected 0", rr); end
    tests++; if (nbusy !== 6'd0 || wcol !== 1'b0) begin fails++; $display("FAIL reset_flags: nbusy %0d wcol %b expected 0/0", nbusy, wcol); end
    model_clear();
    #1 rstd = 1'b0;
    tick();
    // collision write to r3 plus a reservation of r9
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAAAAAAAA;
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'hAAAAAAAA;
    rsv = 1'b1; rsv_a = 5'd9; ra = {5'd9, 5'd3};
    #1;
    tests++; if (rr[31:0] !== 32'hAAAAAAAA) begin fails++; $display("FAIL pre_reset_bypass: got %h expected aaaaaaaa", rr[31:0]); end
    tick();
    tests++; if (wcol !== 1'b1 || nbusy !== 6'd1) begin fails++; $display("FAIL pre_reset_state: wcol %b nbusy %0d expected 1/1", wcol, nbusy); end
    we1 = 1'b0; rsv_a = 5'd10;
    #2 rstd = 1'b1;
    #1;
    tests++; if (rr[31:0] !== 32'h0 || rbusy !== 2'b00) begin fails++; $display("FAIL reset_async_read: rr %h rbusy %b expected 0/00", rr[31:0], rbusy); end
    tests++; if (nbusy !== 6'd0 || wcol !== 1'b0) begin fails++; $display("FAIL reset_async_flags: nbusy %0d wcol %b expected 0/0", nbusy, wcol); end
    model_clear();
    tick();
    tests++; if (nbusy !== 6'd0 || rr[31:0] !== 32'h0) begin fails++; $display("FAIL reset_held: nbusy %0d rr %h expected 0/0", nbusy, rr[31:0]); end
    #3 rstd = 1'b0; idle();
    #1;
    tests++; if (rr[31:0] !== 32'h0 || rbusy !== 2'b00) begin fails++; $display("FAIL reset_release: rr %h rbusy %b expected 0/00", rr[31:0], rbusy); end
  endtask

  task automatic test_bypass();
    logic [31:0] old5;
    old5 = $urandom;
    idle(); we1 = 1'b1; wa1 = 5'd5; wd1 = old5;
    tick();
    idle(); we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h55555555; ra = {5'd5, 5'd4};
    #1;
    tests++; if (rr[31:0] !== 32'h55555555) begin fails++; $display("FAIL bypass_rr0: got %h expected 55555555", rr[31:0]); end
    tests++; if (rr[63:32] !== old5) begin fails++; $display("FAIL bypass_rr1: got %h expected %h", rr[63:32], old5); end
    tick();
    idle();
    #1;
    tests++; if (rr[31:0] !== 32'h55555555) begin fails++; $display("FAIL bypass_stored: got %h expected 55555555", rr[31:0]); end
  endtask

  task automatic test_collision();
    idle();
    we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h12345678;
    we1 = 1'b1; wa1 = 5'd6; wd1 = 32'h87654321;
    ra = {5'd0, 5'd6};
    #1;
    tests++; if (rr[31:0] !== 32'h87654321) begin fails++; $display("FAIL collision_bypass: got %h expected 87654321", rr[31:0]); end
    tests++; if (wcol !== 1'b0) begin fails++; $display("FAIL collision_early: wcol %b expected 0", wcol); end
    tick();
    tests++; if (wcol !== 1'b1) begin fails++; $display("FAIL collision_pulse: wcol %b expected 1", wcol); end
    idle();
    #1;
    tests++; if (rr[31:0] !== 32'h87654321) begin fails++; $display("FAIL collision_stored: got %h expected 87654321", rr[31:0]); end
    tick();
    tests++; if (wcol !== 1'b0) begin fails++; $display("FAIL collision_clear: wcol %b expected 0", wcol); end
  endtask

  task automatic test_reg_zero();
    int nb_before;
    nb_before = m_nbusy;
    idle();
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h11111111;
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h11111111;
    rsv = 1'b1; rsv_a = 5'd0; ra = {5'd0, 5'd0};
    #1;
    tests++; if (rr !== 64'h0 || rbusy !== 2'b00) begin fails++; $display("FAIL zero_read: rr %h rbusy %b expected 0/00", rr, rbusy); end
    tick();
    tests++; if (int'(nbusy) != nb_before || wcol !== 1'b0) begin fails++; $display("FAIL zero_flags: nbusy %0d wcol %b expected %0d/0", nbusy, wcol, nb_before); end
    idle();
    #1;
    tests++; if (rr !== 64'h0) begin fails++; $display("FAIL zero_stored: got %h expected 0", rr); end
  endtask

  task automatic test_scoreboard();
    logic [31:0] d8;
    idle(); rsv = 1'b1; rsv_a = 5'd7; ra = {5'd0, 5'd7};
    #1;
    tests++; if (rbusy[0] !== 1'b0) begin fails++; $display("FAIL sb_rsv_same_cycle: rbusy %b expected 0", rbusy[0]); end
    tick();
    rsv_a = 5'd8;
    tick();
    idle();
    #1;
    tests++; if (nbusy !== 6'd2 || rbusy[0] !== 1'b1) begin fails++; $display("FAIL sb_two_busy: nbusy %0d rbusy %b expected 2/1", nbusy, rbusy[0]); end
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h77777777; rsv = 1'b1; rsv_a = 5'd7;
    #1;
    tests++; if (rbusy[0] !== 1'b1 || rr[31:0] !== 32'h77777777) begin fails++; $display("FAIL sb_wr_rsv_view: rbusy %b rr %h expected 1/77777777", rbusy[0], rr[31:0]); end
    tick();
    idle();
    #1;
    tests++; if (nbusy !== 6'd2 || rbusy[0] !== 1'b1 || rr[31:0] !== 32'h77777777) begin fails++; $display("FAIL sb_wr_rsv_after: nbusy %0d rbusy %b rr %h expected 2/1/77777777", nbusy, rbusy[0], rr[31:0]); end
    d8 = $urandom;
    we1 = 1'b1; wa1 = 5'd8; wd1 = d8; ra = {5'd8, 5'd7};
    #1;
    tests++; if (rbusy[1] !== 1'b0 || rr[63:32] !== d8) begin fails++; $display("FAIL sb_writeback_view: rbusy %b rr %h expected 0/%h", rbusy[1], rr[63:32], d8); end
    tick();
    tests++; if (nbusy !== 6'd1) begin fails++; $display("FAIL sb_writeback_count: nbusy %0d expected 1", nbusy); end
    idle();
  endtask

  task automatic test_nr4();
    int big;
    idle();
    we0_4 = 1'b1; wa0_4 = 3'd4; wd0_4 = 32'hA0;
    we1_4 = 1'b1; wa1_4 = 3'd5; wd1_4 = 32'hA1;
    tick();
    wa0_4 = 3'd6; wd0_4 = 32'hA2;
    wa1_4 = 3'd7; wd1_4 = 32'hA3;
    tick();
    wa0_4 = 3'd1; wd0_4 = 32'h12;
    wa1_4 = 3'd5; wd1_4 = 32'hDEADBEEF;
    ra4 = {3'd6, 3'd5, 3'd4, 3'd7};
    #1;
    tests++; if (rr4 !== {32'hA2, 32'hDEADBEEF, 32'hA0, 32'hA3}) begin fails++; $display("FAIL nr4_slicing: got %h expected a2/deadbeef/a0/a3", rr4); end
    tests++; if (rbusy4 !== 4'b0000) begin fails++; $display("FAIL nr4_rbusy: got %b expected 0000", rbusy4); end
    tick();
    idle();
    big = 15;
    we0_4 = 1'b1; wa0_4 = big[2:0]; wd0_4 = 32'hB7; rsv4 = 1'b1; rsv_a4 = 3'd2;
    ra4 = {3'd1, 3'd5, 3'd7, 3'd0};
    #1;
    tests++; if (rr4 !== {32'h12, 32'hDEADBEEF, 32'hB7, 32'h0}) begin fails++; $display("FAIL nr4_wrap: got %h expected 12/deadbeef/b7/0", rr4); end
    tick();
    idle();
    #1;
    tests++; if (nbusy4 !== 4'd1 || rr4[63:32] !== 32'hB7) begin fails++; $display("FAIL nr4_after: nbusy %0d r7 %h expected 1/b7", nbusy4, rr4[63:32]); end
  endtask

  task automatic test_random();
    logic [4:0] a;
    for (int i = 0; i < 400; i++) begin
      we0 = 1'($urandom_range(0, 1)); wa0 = pick_addr();
      wd0 = we0 ? 32'($urandom) : 32'hxxxxxxxx;
      we1 = 1'($urandom_range(0, 1)); wa1 = pick_addr();
      wd1 = we1 ? 32'($urandom) : 32'hxxxxxxxx;
      rsv = ($urandom_range(0, 2) == 0); rsv_a = pick_addr();
      ra = {pick_addr(), pick_addr()};
      #1;
      for (int k = 0; k < 2; k++) begin
        a = ra[k*5 +: 5];
        tests++;
        if (rr[k*32 +: 32] !== exp_rd(a)) begin
          fails++; $display("FAIL rand_rr%0d cyc %0d addr %0d: got %h expected %h", k, i, a, rr[k*32 +: 32], exp_rd(a));
        end
        tests++;
        if (rbusy[k] !== exp_busy(a)) begin
          fails++; $display("FAIL rand_rbusy%0d cyc %0d addr %0d: got %b expected %b", k, i, a, rbusy[k], exp_busy(a));
        end
      end
      tick();
      tests++;
      if (int'(nbusy) != m_nbusy || wcol !== m_wcol) begin
        fails++; $display("FAIL rand_flags cyc %0d: nbusy %0d wcol %b expected %0d/%b", i, nbusy, wcol, m_nbusy, m_wcol);
      end
    end
    idle();
    for (int r = 0; r < 32; r += 2) begin
      ra = {5'(r + 1), 5'(r)};
      #1;
      tests++;
      if (rr !== {m_mem[r + 1], (r == 0) ? 32'h0 : m_mem[r]}) begin
        fails++; $display("FAIL sweep r%0d: got %h expected %h_%h", r, rr, m_mem[r + 1], (r == 0) ? 32'h0 : m_mem[r]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_collision();
    test_reg_zero();
    test_scoreboard();
    test_nr4();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the single-write, dual-read register file.
- Configurable data width, address width and read-port count.
- Two write ports with fixed priority and write-through bypass on all reads.
- Per-register busy (scoreboard) bit set at issue and cleared at writeback. The RISC pipeline uses it for decode-stage hazard detection.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2^AW registers.
- NR, 2, number of read ports (1..4).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstd  input  1  reset, asynchronous, active-high.
- ra  input  NR*AW  read addresses; port k uses bits [k*AW +: AW].
- rr  output  NR*DW  read data; port k uses bits [k*DW +: DW].
- rbusy  output  NR  busy bit of the register addressed by ra port k.
- we0  input  1  write enable, port 0, active-high.
- wa0  input  AW  write address, port 0.
- wd0  input  DW  write data, port 0.
- we1  input  1  write enable, port 1, active-high.
- wa1  input  AW  write address, port 1.
- wd1  input  DW  write data, port 1.
- rsv  input  1  reserve request; marks register rsv_a busy.
- rsv_a  input  AW  register being reserved.
- wcol  output  1  registered flag: same-cycle dual write to one nonzero address.
- nbusy  output  AW+1  count of currently busy registers.

Behaviour:
- Reset (rstd=1, asynchronous, takes effect immediately):
  - all registers = 0, all busy bits = 0, wcol = 0, nbusy = 0.
  - Held while rstd=1: writes and reservations are ignored.
  - Reads during reset return 0 with rbusy = 0, because the bypass is suppressed while rstd=1.
- Register 0:
  - reads always return 0, busy always 0.
  - Writes and reservations to address 0 are discarded, with no effect on wcol or nbusy.
- Write, at the rising edge:
  - if we0 and wa0≠0, reg[wa0] <= wd0.
  - if we1 and wa1≠0, reg[wa1] <= wd1.
  - If wa0 == wa1 and both are enabled, port 1 wins.
- Read (combinational, per port k):
  - if we1 and wa1 == ra_k ≠ 0, rr_k = wd1;
  - else if we0 and wa0 == ra_k ≠ 0, rr_k = wd0;
  - else rr_k = reg[ra_k].
  - Zero added latency; same-cycle write-through.
- Busy bits, at the rising edge, for each nonzero address a:
  - set if rsv and rsv_a == a;
  - else cleared if (we0 and wa0 == a) or (we1 and wa1 == a);
  - else hold.
  - Reserve beats writeback on the same address in the same cycle, because a new producer supersedes the old one.
- rbusy_k (combinational) reflects the post-bypass view:
  - 0 if a write to ra_k is active this cycle and no reserve to ra_k is active this cycle;
  - otherwise the stored busy bit.
  - Reserving an idle register does not make rbusy high until the next cycle.
- wcol:
  - next value = we0 & we1 & (wa0 == wa1) & (wa0 ≠ 0).
  - A one-cycle pulse registered at the edge, valid the cycle after the collision.
- nbusy:
  - registered population count of the busy bits, updated at the same edge as the bits.
  - Range 0..2^AW−1; it never counts register 0.
- Writing a register that is not busy is legal; the busy bit stays 0.
- Reserving a register that is already busy is legal; it stays busy and nbusy does not change.
- No X propagation: the enables are qualified before use, so X data on disabled ports must not corrupt state.

Test Plan:
1. Reset mid-write:
   - Stimulus: write 0xAAAAAAAA to r3; assert rstd between edges; deassert.
   - Required: r3 reads 0, nbusy = 0, wcol = 0 immediately on rstd rising, without waiting for a clock.
2. Bypass:
   - Stimulus: same cycle, we0 = 1, wa0 = 4, wd0 = 0x55555555, ra port0 = 4, ra port1 = 5.
   - Required: rr0 = 0x55555555 before the edge, rr1 = old r5; after the edge r4 = 0x55555555 on a plain read.
3. Dual-write collision:
   - Stimulus: we0 = we1 = 1, wa0 = wa1 = 6, wd0 = 0x12345678, wd1 = 0x87654321.
   - Required: rr on r6 = 0x87654321; r6 stores 0x87654321; wcol = 1 for exactly one cycle after the edge.
4. Register zero:
   - Stimulus: write 0x11111111 to r0 via both ports, plus rsv_a = 0.
   - Required: rr = 0, rbusy = 0, nbusy unchanged, wcol stays 0.
5. Scoreboard:
   - Stimulus: reserve r7, then r8 → nbusy = 2 and rbusy on r7 = 1. Then in one cycle: write r7 with 0x77777777 on port 0 and reserve r7.
   - Required: r7 = 0x77777777, still busy, nbusy = 2.
   - Then write r8 with no reserve → rbusy on r8 = 0 in that same cycle, and nbusy = 1 after the edge.
6. NR = 4 instance, AW = 3:
   - Stimulus: all four read ports on distinct registers loaded with 0xA0..0xA3, one port aliased to an active port-1 write.
   - Required: correct per-port slicing; the aliased port shows the port-1 write data; address wraps at r7.
